// File: rtl/fft_input_mix.sv
// Packs a serial complex-sample frame into 4-lane words rotated by the group's base-4 digit sum mod 4.
// Optional FFT_IN_ERR_EN adds a sticky oERR flag for ignored control events.
module fft_input_mix #(
  parameter int BIT    = 17,
  parameter int N_LOG2 = 8
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iSTART,
  input  logic                  iVALID,
  input  logic signed [BIT-1:0] iRE,
  input  logic signed [BIT-1:0] iIM,
  output logic signed [BIT-1:0] oY0_RE,
  output logic signed [BIT-1:0] oY1_RE,
  output logic signed [BIT-1:0] oY2_RE,
  output logic signed [BIT-1:0] oY3_RE,
  output logic signed [BIT-1:0] oY0_IM,
  output logic signed [BIT-1:0] oY1_IM,
  output logic signed [BIT-1:0] oY2_IM,
  output logic signed [BIT-1:0] oY3_IM,
  output logic                  oVALID,
  output logic [N_LOG2-3:0]     oADDR,
  output logic [1:0]            oSEL,
  output logic                  oBUSY,
  output logic                  oDONE
`ifdef FFT_IN_ERR_EN
  ,output logic                 oERR
`endif
);

  localparam int G_W   = N_LOG2 - 2;
  localparam int N_DIG = G_W / 2;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                r_state, w_state_next;
  logic [N_LOG2-1:0]     r_idx;
  logic signed [BIT-1:0] r_stage_re [0:2];
  logic signed [BIT-1:0] r_stage_im [0:2];
  logic signed [BIT-1:0] r_y_re [0:3];
  logic signed [BIT-1:0] r_y_im [0:3];
  logic                  r_valid, r_done;
  logic [G_W-1:0]        r_addr;
  logic [1:0]            r_sel;

  logic                  w_accept, w_last, w_group_end;
  logic [G_W-1:0]        w_g;
  logic [1:0]            w_sel;
  logic signed [BIT-1:0] w_lane_re [0:3];
  logic signed [BIT-1:0] w_lane_im [0:3];
  logic signed [BIT-1:0] w_rot_re  [0:3];
  logic signed [BIT-1:0] w_rot_im  [0:3];

  assign w_accept    = (r_state == LOAD) && iVALID;
  assign w_group_end = w_accept && (r_idx[1:0] == 2'd3);
  assign w_last      = w_accept && (r_idx == {N_LOG2{1'b1}});
  assign w_g         = r_idx[N_LOG2-1:2];

  // Digit sum mod 4: 2-bit accumulation wraps naturally.
  always_comb begin
    w_sel = '0;
    for (int d = 0; d < N_DIG; d++) begin
      w_sel = w_sel + w_g[2*d +: 2];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (iSTART) w_state_next = LOAD;
      LOAD:    if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Slot 3 bypasses staging so the word is complete on the accepting edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_K = 2'(gi);
      if (gi == 3) begin : g_direct
        assign w_lane_re[gi] = iRE;
        assign w_lane_im[gi] = iIM;
      end else begin : g_staged
        assign w_lane_re[gi] = r_stage_re[gi];
        assign w_lane_im[gi] = r_stage_im[gi];
      end
      assign w_rot_re[gi] = w_lane_re[LANE_K - w_sel];
      assign w_rot_im[gi] = w_lane_im[LANE_K - w_sel];
    end
  endgenerate

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      for (int k = 0; k < 3; k++) begin
        r_stage_re[k] <= '0;
        r_stage_im[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        r_y_re[k] <= '0;
        r_y_im[k] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_valid <= w_group_end;
      r_done  <= w_last;
      if (r_state == IDLE && iSTART) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_accept && r_idx[1:0] != 2'd3) begin
        r_stage_re[r_idx[1:0]] <= iRE;
        r_stage_im[r_idx[1:0]] <= iIM;
      end
      if (w_group_end) begin
        r_addr <= w_g;
        r_sel  <= w_sel;
        for (int k = 0; k < 4; k++) begin
          r_y_re[k] <= w_rot_re[k];
          r_y_im[k] <= w_rot_im[k];
        end
      end
    end
  end

`ifdef FFT_IN_ERR_EN
  logic r_err;
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && iSTART) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE && iVALID) || (r_state == LOAD && iSTART)) begin
      r_err <= 1'b1;
    end
  end
  assign oERR = r_err;
`endif

  assign oY0_RE = r_y_re[0];
  assign oY1_RE = r_y_re[1];
  assign oY2_RE = r_y_re[2];
  assign oY3_RE = r_y_re[3];
  assign oY0_IM = r_y_im[0];
  assign oY1_IM = r_y_im[1];
  assign oY2_IM = r_y_im[2];
  assign oY3_IM = r_y_im[3];
  assign oVALID = r_valid;
  assign oDONE  = r_done;
  assign oADDR  = r_addr;
  assign oSEL   = r_sel;
  assign oBUSY  = (r_state == LOAD);

endmodule
